// File: rtl/hazard_fwd_unit_pkg.sv
// Shared pipeline definitions for the hazard/forwarding unit:
// operand-source select encodings and the NOP bubble slot value.
package hazard_fwd_unit_pkg;

    // ID operand source select.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,   // register file
        FWD_EXE = 2'b01,   // EXE ALU result
        FWD_MEM = 2'b10,   // MEM result (ALU or load data)
        FWD_WB  = 2'b11    // WB data
    } fwd_sel_e;

    // Scoreboard slot value injected when ID is stalled (a NOP writes nothing).
    localparam logic        SB_NOP_WREG    = 1'b0;
    localparam logic        SB_NOP_MEM2REG = 1'b0;
    localparam int unsigned SB_NOP_RD      = 0;

endpackage

// File: rtl/hazard_fwd_unit_sb_slot.sv
// One scoreboard slot: a {wreg, mem2reg, rd} register with load enable
// and asynchronous clear.
module hazard_sb_slot
    import hazard_fwd_unit_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            i_clk,
    input  logic            i_resetn,
    input  logic            en_i,
    input  logic            wreg_i,
    input  logic            mem2reg_i,
    input  logic [RA_W-1:0] rd_i,
    output logic            wreg_o,
    output logic            mem2reg_o,
    output logic [RA_W-1:0] rd_o
);

    logic            wreg_q;
    logic            mem2reg_q;
    logic [RA_W-1:0] rd_q;

    // Slot register: cleared asynchronously, loaded only when the pipe advances.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            wreg_q    <= 1'b0;
            mem2reg_q <= 1'b0;
            rd_q      <= '0;
        end else if (en_i) begin
            wreg_q    <= wreg_i;
            mem2reg_q <= mem2reg_i;
            rd_q      <= rd_i;
        end
    end

    assign wreg_o    = wreg_q;
    assign mem2reg_o = mem2reg_q;
    assign rd_o      = rd_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard detection and operand forwarding. Tracks the destination
// of the instructions in EXE, MEM and WB, selects forwarding sources for the
// ID operands, stalls on load-use, squashes fetch on redirect and counts
// stall / flush events.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int RA_W  = 5
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic [RA_W-1:0]  i_id_rs1,
    input  logic [RA_W-1:0]  i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [RA_W-1:0]  i_id_rd,
    input  logic             i_id_wreg,
    input  logic             i_id_mem2reg,
    input  logic             i_id_redirect,
    input  logic             i_hold,
    output logic             o_stall,
    output logic             o_bubble,
    output logic             o_flush_if,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    logic            exe_wreg, exe_mem2reg, mem_wreg, mem_mem2reg, wb_wreg, wb_mem2reg;
    logic [RA_W-1:0] exe_rd, mem_rd, wb_rd;

    logic            exe_wreg_d, exe_mem2reg_d;
    logic [RA_W-1:0] exe_rd_d;
    logic            advance;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    function automatic logic slot_match(input logic            wreg,
                                        input logic [RA_W-1:0] rd,
                                        input logic [RA_W-1:0] rs,
                                        input logic            use_rs);
        return wreg && (rd != '0) && (rd == rs) && use_rs;
    endfunction

    assign advance = !i_hold;

    // Entry into EXE: a stalled ID instruction is replaced by a NOP bubble.
    always_comb begin
        exe_wreg_d    = i_id_wreg;
        exe_mem2reg_d = i_id_mem2reg;
        exe_rd_d      = i_id_rd;
        if (o_stall) begin
            exe_wreg_d    = SB_NOP_WREG;
            exe_mem2reg_d = SB_NOP_MEM2REG;
            exe_rd_d      = RA_W'(SB_NOP_RD);
        end
    end

    hazard_sb_slot #(.RA_W(RA_W)) u_slot_exe (
        .i_clk(i_clk), .i_resetn(i_resetn), .en_i(advance),
        .wreg_i(exe_wreg_d), .mem2reg_i(exe_mem2reg_d), .rd_i(exe_rd_d),
        .wreg_o(exe_wreg), .mem2reg_o(exe_mem2reg), .rd_o(exe_rd)
    );

    hazard_sb_slot #(.RA_W(RA_W)) u_slot_mem (
        .i_clk(i_clk), .i_resetn(i_resetn), .en_i(advance),
        .wreg_i(exe_wreg), .mem2reg_i(exe_mem2reg), .rd_i(exe_rd),
        .wreg_o(mem_wreg), .mem2reg_o(mem_mem2reg), .rd_o(mem_rd)
    );

    hazard_sb_slot #(.RA_W(RA_W)) u_slot_wb (
        .i_clk(i_clk), .i_resetn(i_resetn), .en_i(advance),
        .wreg_i(mem_wreg), .mem2reg_i(mem_mem2reg), .rd_i(mem_rd),
        .wreg_o(wb_wreg), .mem2reg_o(wb_mem2reg), .rd_o(wb_rd)
    );

    // Load-use detection, bubble and fetch squash. A stall wins over a redirect;
    // the redirect is seen again once the stall clears.
    always_comb begin
        o_stall = exe_mem2reg &&
                  (slot_match(exe_wreg, exe_rd, i_id_rs1, i_id_use_rs1) ||
                   slot_match(exe_wreg, exe_rd, i_id_rs2, i_id_use_rs2));
        o_bubble   = o_stall && !i_hold;
        o_flush_if = i_id_redirect && !o_stall && !i_hold;
    end

    // Operand source selection, youngest producer first.
    always_comb begin
        o_fwd_a = FWD_RF;
        if (slot_match(exe_wreg, exe_rd, i_id_rs1, i_id_use_rs1))      o_fwd_a = FWD_EXE;
        else if (slot_match(mem_wreg, mem_rd, i_id_rs1, i_id_use_rs1)) o_fwd_a = FWD_MEM;
        else if (slot_match(wb_wreg, wb_rd, i_id_rs1, i_id_use_rs1))   o_fwd_a = FWD_WB;

        o_fwd_b = FWD_RF;
        if (slot_match(exe_wreg, exe_rd, i_id_rs2, i_id_use_rs2))      o_fwd_b = FWD_EXE;
        else if (slot_match(mem_wreg, mem_rd, i_id_rs2, i_id_use_rs2)) o_fwd_b = FWD_MEM;
        else if (slot_match(wb_wreg, wb_rd, i_id_rs2, i_id_use_rs2))   o_fwd_b = FWD_WB;
    end

    // Saturating event counters; frozen while the pipeline is held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!i_hold) begin
            if (o_stall && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + 1'b1;
            if (o_flush_if && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

    // WB mem2reg is carried for completeness of the slot but not consumed here.
    logic unused_wb_mem2reg;
    assign unused_wb_mem2reg = wb_mem2reg;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    localparam int CNT_W = 2;
    localparam int RA_W  = 5;

    logic             i_clk = 1'b0;
    logic             i_resetn = 1'b0;
    logic [RA_W-1:0]  i_id_rs1 = '0, i_id_rs2 = '0, i_id_rd = '0;
    logic             i_id_use_rs1 = 0, i_id_use_rs2 = 0, i_id_wreg = 0, i_id_mem2reg = 0;
    logic             i_id_redirect = 0, i_hold = 0;
    logic             o_stall, o_bubble, o_flush_if;
    logic [1:0]       o_fwd_a, o_fwd_b;
    logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

    int total = 0;
    int bad   = 0;

    hazard_fwd_unit #(.CNT_W(CNT_W), .RA_W(RA_W)) dut (
        .i_clk(i_clk), .i_resetn(i_resetn),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
        .i_id_rd(i_id_rd), .i_id_wreg(i_id_wreg), .i_id_mem2reg(i_id_mem2reg),
        .i_id_redirect(i_id_redirect), .i_hold(i_hold),
        .o_stall(o_stall), .o_bubble(o_bubble), .o_flush_if(o_flush_if),
        .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- behavioural model ----------------
    // pipe[0]=EXE, pipe[1]=MEM, pipe[2]=WB; each entry: writes, is_load, rd
    bit m_w[3];
    bit m_ld[3];
    int m_rd[3];
    int m_scnt, m_fcnt;
    int cnt_max = (1 << CNT_W) - 1;

    function automatic bit hits(int k, int rs, bit used);
        return used && m_w[k] && m_rd[k] != 0 && m_rd[k] == rs;
    endfunction

    function automatic int src_for(int rs, bit used);
        for (int k = 0; k < 3; k++)
            if (hits(k, rs, used)) return k + 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        return m_ld[0] && (hits(0, int'(i_id_rs1), i_id_use_rs1) || hits(0, int'(i_id_rs2), i_id_use_rs2));
    endfunction

    function automatic bit exp_flush();
        return i_id_redirect && !exp_stall() && !i_hold;
    endfunction

    always @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int k = 0; k < 3; k++) begin m_w[k] = 0; m_ld[k] = 0; m_rd[k] = 0; end
            m_scnt = 0; m_fcnt = 0;
        end else if (!i_hold) begin
            bit st, fl;
            st = exp_stall();
            fl = exp_flush();
            for (int k = 2; k > 0; k--) begin
                m_w[k] = m_w[k-1]; m_ld[k] = m_ld[k-1]; m_rd[k] = m_rd[k-1];
            end
            m_w[0]  = st ? 0 : i_id_wreg;
            m_ld[0] = st ? 0 : i_id_mem2reg;
            m_rd[0] = st ? 0 : int'(i_id_rd);
            if (st) m_scnt = (m_scnt + 1 > cnt_max) ? cnt_max : m_scnt + 1;
            if (fl) m_fcnt = (m_fcnt + 1 > cnt_max) ? cnt_max : m_fcnt + 1;
        end
    end

    task automatic cmp(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge i_clk) begin
        bit st;
        st = exp_stall();
        cmp("m_stall", int'(o_stall), int'(st));
        cmp("m_bubble", int'(o_bubble), int'(st && !i_hold));
        cmp("m_flush_if", int'(o_flush_if), int'(exp_flush()));
        if (!st) begin
            cmp("m_fwd_a", int'(o_fwd_a), src_for(int'(i_id_rs1), i_id_use_rs1));
            cmp("m_fwd_b", int'(o_fwd_b), src_for(int'(i_id_rs2), i_id_use_rs2));
        end
        cmp("m_stall_cnt", int'(o_stall_cnt), m_scnt);
        cmp("m_flush_cnt", int'(o_flush_cnt), m_fcnt);
    end

    // ---------------- stimulus ----------------
    task automatic drive(int rs1, bit u1, int rs2, bit u2, int rd, bit w, bit ld, bit redir, bit hold);
        @(posedge i_clk); #1;
        i_id_rs1 = RA_W'(rs1); i_id_use_rs1 = u1;
        i_id_rs2 = RA_W'(rs2); i_id_use_rs2 = u2;
        i_id_rd = RA_W'(rd); i_id_wreg = w; i_id_mem2reg = ld;
        i_id_redirect = redir; i_hold = hold;
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int saved_s, saved_f;

    initial begin
        #12;
        cmp("rst_stall", int'(o_stall), 0);
        cmp("rst_scnt", int'(o_stall_cnt), 0);
        cmp("rst_fwd_a", int'(o_fwd_a), 0);
        i_id_redirect = 1; #1;
        cmp("rst_flush_if", int'(o_flush_if), 1);
        i_id_redirect = 0;
        @(negedge i_clk); i_resetn = 1;

        // ALU write x5, consumer rs1=5
        drive(0, 0, 0, 0, 5, 1, 0, 0, 0);
        drive(5, 1, 0, 0, 0, 0, 0, 0, 0);
        cmp("alu_fwd_a", int'(o_fwd_a), 1);
        cmp("alu_stall", int'(o_stall), 0);

        // load x7, consumer rs2=7
        drive(0, 0, 0, 0, 7, 1, 1, 0, 0);
        drive(0, 0, 7, 1, 0, 0, 0, 0, 0);
        cmp("lu_stall", int'(o_stall), 1);
        cmp("lu_bubble", int'(o_bubble), 1);
        drive(0, 0, 7, 1, 0, 0, 0, 0, 0);
        cmp("lu_after_stall", int'(o_stall), 0);
        cmp("lu_fwd_b", int'(o_fwd_b), 2);
        cmp("lu_scnt", int'(o_stall_cnt), 1);

        // x3 in all three stages, then with a non-writing EXE
        drive(0, 0, 0, 0, 3, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 3, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 3, 1, 0, 0, 0);
        drive(3, 1, 0, 0, 0, 0, 0, 0, 0);
        cmp("prio_exe", int'(o_fwd_a), 1);
        drive(3, 1, 0, 0, 0, 0, 0, 0, 0);
        cmp("prio_mem", int'(o_fwd_a), 2);

        // x0 is never forwarded
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
        cmp("x0_fwd_a", int'(o_fwd_a), 0);
        cmp("x0_stall", int'(o_stall), 0);

        // load-use with redirect
        drive(0, 0, 0, 0, 9, 1, 1, 0, 0);
        drive(9, 1, 0, 0, 0, 0, 0, 1, 0);
        saved_f = int'(o_flush_cnt);
        cmp("redir_stall", int'(o_stall), 1);
        cmp("redir_flush_if", int'(o_flush_if), 0);
        drive(9, 1, 0, 0, 0, 0, 0, 1, 0);
        cmp("redir_fcnt", int'(o_flush_cnt), saved_f);
        cmp("redir_flush_next", int'(o_flush_if), 1);
        nop();
        cmp("redir_fcnt_inc", int'(o_flush_cnt), saved_f + 1);

        // load-use under hold
        drive(0, 0, 0, 0, 4, 1, 1, 0, 0);
        drive(4, 1, 0, 0, 0, 0, 0, 0, 1);
        saved_s = int'(o_stall_cnt);
        saved_f = int'(o_flush_cnt);
        cmp("hold_stall", int'(o_stall), 1);
        cmp("hold_bubble", int'(o_bubble), 0);
        drive(4, 1, 0, 0, 0, 0, 0, 0, 1);
        drive(4, 1, 0, 0, 0, 0, 0, 1, 1);
        cmp("hold_scnt", int'(o_stall_cnt), saved_s);
        cmp("hold_fcnt", int'(o_flush_cnt), saved_f);
        drive(4, 1, 0, 0, 0, 0, 0, 0, 0);
        cmp("release_bubble", int'(o_bubble), 1);
        drive(4, 1, 0, 0, 0, 0, 0, 0, 0);
        cmp("release_one_bubble", int'(o_bubble), 0);
        cmp("release_fwd_a", int'(o_fwd_a), 2);

        // repeated stalls saturate the 2-bit counter
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 6, 1, 1, 0, 0);
            drive(0, 0, 6, 1, 0, 0, 0, 0, 0);
            drive(0, 0, 6, 1, 0, 0, 0, 0, 0);
        end
        cmp("sat_scnt", int'(o_stall_cnt), 3);

        // reset mid-stall clears the stall immediately
        drive(0, 0, 0, 0, 8, 1, 1, 0, 0);
        drive(8, 1, 0, 0, 0, 0, 0, 0, 0);
        cmp("pre_rst_stall", int'(o_stall), 1);
        i_resetn = 0; #1;
        cmp("rst_mid_stall", int'(o_stall), 0);
        cmp("rst_mid_scnt", int'(o_stall_cnt), 0);
        @(negedge i_clk); i_resetn = 1;

        // randomized traffic; small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            drive(int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        end
        nop();
        @(posedge i_clk); #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
